// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: per-register countdown scoreboard for RAW stalls
// plus fetch freeze/flush around control transfers. Define FWD_EN for forwarding latencies.
module hazard_ctrl #(
  parameter int NREG    = 8,
  parameter int WB_DIST = 3,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [2:0]       id_src1,
  input  logic [2:0]       id_src2,
  input  logic [2:0]       id_dest,
  input  logic [2:0]       id_wb,
  input  logic [1:0]       id_mem,
  input  logic             ex_br_resolved,
  input  logic             ex_br_taken,
  output logic             issue,
  output logic             stall_fe,
  output logic             flush_fe,
  output logic             bubble_ex,
  output logic [NREG-1:0]  busy_mask,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       cnt_q [NREG];
  logic [1:0]       cnt_d [NREG];
  logic [NREG-1:0]  busy_mask_q, busy_mask_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic uses_src1, uses_src2, is_ctrl;
  logic src1_busy, src2_busy, hazard;
  logic [1:0] wr_lat;

  // Only the write-enable bit of the WB code matters to the scoreboard.
  logic unused_ok;
  assign unused_ok = ^{id_wb[1:0], id_mem};

  // NOTE: combinational blocks assign every output a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    uses_src1 = 1'b0;
    uses_src2 = 1'b0;
    is_ctrl   = 1'b0;
    unique case (id_opcode)
      4'b0001, 4'b0010, 4'b0101: begin
        uses_src1 = 1'b1;
        uses_src2 = 1'b1;
      end
      4'b1000: begin
        uses_src1 = 1'b1;
        uses_src2 = 1'b1;
        is_ctrl   = 1'b1;
      end
      4'b0000, 4'b0100: uses_src1 = 1'b1;
      4'b1011: begin
        uses_src1 = 1'b1;
        is_ctrl   = 1'b1;
      end
      4'b1010: begin
        uses_src2 = 1'b1;
        is_ctrl   = 1'b1;
      end
      4'b1001: is_ctrl = 1'b1;
      default: ;
    endcase
  end

  assign src1_busy = (cnt_q[id_src1] != 2'd0);
  assign src2_busy = (cnt_q[id_src2] != 2'd0);
  assign hazard    = id_valid & ((uses_src1 & src1_busy) | (uses_src2 & src2_busy));

`ifdef FWD_EN
  // EX/MEM forwarding covers ALU results; only a load's data arrives one cycle late.
  assign wr_lat = (id_mem == 2'b01) ? 2'd1 : 2'd0;
`else
  assign wr_lat = 2'(WB_DIST);
`endif

  always_comb begin
    issue     = 1'b0;
    stall_fe  = 1'b0;
    flush_fe  = 1'b0;
    bubble_ex = 1'b1;
    state_d   = state_q;
    if (!rst) begin
      unique case (state_q)
        ST_RUN: begin
          if (hazard) begin
            stall_fe = 1'b1;
          end else if (id_valid) begin
            issue     = 1'b1;
            bubble_ex = 1'b0;
            if (is_ctrl) state_d = ST_BR_WAIT;
          end
        end
        ST_BR_WAIT: begin
          stall_fe = 1'b1;
          if (ex_br_resolved) begin
            state_d = ST_RUN;
            // A not-taken resolution keeps stall_fe high so the fall-through stays in IF/ID.
            if (ex_br_taken) begin
              flush_fe = 1'b1;
              stall_fe = 1'b0;
            end
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != 2'd0) ? cnt_q[r] - 2'd1 : 2'd0;
    end
    // The issue-time load overrides this cycle's decrement of the same entry.
    if (issue && id_wb[2]) cnt_d[id_dest] = wr_lat;
    for (int r = 0; r < NREG; r++) begin
      busy_mask_d[r] = (cnt_d[r] != 2'd0);
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (state_q == ST_RUN && hazard && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      busy_mask_q    <= '0;
      stall_cycles_q <= '0;
      // NOTE: the scoreboard array is reset explicitly; a stale count after reset
      // would stall the first instructions on phantom writes.
      for (int r = 0; r < NREG; r++) cnt_q[r] <= 2'd0;
    end else begin
      state_q        <= state_d;
      busy_mask_q    <= busy_mask_d;
      stall_cycles_q <= stall_cycles_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign busy_mask    = busy_mask_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector tables plus random stimulus
// against a cycle-timestamp reference model.
module tb_hazard_ctrl;
  localparam int NREG    = 8;
  localparam int WB_DIST = 3;
  localparam int CNT_W   = 16;
  localparam int SC_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [3:0]       id_opcode;
  logic [2:0]       id_src1, id_src2, id_dest, id_wb;
  logic [1:0]       id_mem;
  logic             ex_br_resolved, ex_br_taken;
  logic             issue, stall_fe, flush_fe, bubble_ex;
  logic [NREG-1:0]  busy_mask;
  logic [CNT_W-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_ctrl #(.NREG(NREG), .WB_DIST(WB_DIST), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest), .id_wb(id_wb),
    .id_mem(id_mem), .ex_br_resolved(ex_br_resolved), .ex_br_taken(ex_br_taken),
    .issue(issue), .stall_fe(stall_fe), .flush_fe(flush_fe), .bubble_ex(bubble_ex),
    .busy_mask(busy_mask), .stall_cycles(stall_cycles)
  );

  typedef struct {
    logic       rst, valid;
    logic [3:0] op;
    logic [2:0] s1, s2, d, wb;
    logic [1:0] mem;
    logic       res, tkn;
    logic       e_issue, e_stall, e_flush, e_bubble;
    logic [7:0] e_busy;
    int         e_sc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: each register records the first cycle at which it is free.
  int cyc = 0;
  bit m_br = 1'b0;
  int m_free [NREG];
  int m_sc = 0;

  function automatic vec_t mk(input logic r, v, input logic [3:0] op,
                              input logic [2:0] s1, s2, d, wb, input logic [1:0] mem,
                              input logic res, tkn, ei, es, ef, eb,
                              input logic [7:0] ebusy, input int esc);
    vec_t x;
    x.rst = r; x.valid = v; x.op = op; x.s1 = s1; x.s2 = s2; x.d = d; x.wb = wb;
    x.mem = mem; x.res = res; x.tkn = tkn; x.e_issue = ei; x.e_stall = es;
    x.e_flush = ef; x.e_bubble = eb; x.e_busy = ebusy; x.e_sc = esc;
    return x;
  endfunction

  function automatic bit reads1(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd8, 4'd11};
  endfunction
  function automatic bit reads2(input logic [3:0] op);
    return op inside {4'd1, 4'd2, 4'd5, 4'd8, 4'd10};
  endfunction
  function automatic bit transfers(input logic [3:0] op);
    return op inside {[4'd8:4'd11]};
  endfunction
  function automatic int latency(input logic [1:0] mem);
`ifdef FWD_EN
    return (mem == 2'b01) ? 1 : 0;
`else
    return WB_DIST;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic run_cycle(input vec_t v, input bit use_tab);
    logic       o_issue, o_stall, o_flush, o_bubble, haz;
    logic [7:0] o_busy;
    int         o_sc;
    rst = v.rst; id_valid = v.valid; id_opcode = v.op; id_src1 = v.s1; id_src2 = v.s2;
    id_dest = v.d; id_wb = v.wb; id_mem = v.mem; ex_br_resolved = v.res; ex_br_taken = v.tkn;
    @(negedge clk);
    for (int r = 0; r < NREG; r++) o_busy[r] = (cyc < m_free[r]);
    o_sc = m_sc;
    haz = v.valid && ((reads1(v.op) && cyc < m_free[v.s1]) || (reads2(v.op) && cyc < m_free[v.s2]));
    o_issue = 0; o_stall = 0; o_flush = 0; o_bubble = 1;
    if (!v.rst) begin
      if (m_br) begin
        o_flush = v.res && v.tkn;
        o_stall = !o_flush;
      end else if (haz) begin
        o_stall = 1;
      end else if (v.valid) begin
        o_issue = 1; o_bubble = 0;
      end
    end
    if (use_tab) begin
      o_issue = v.e_issue; o_stall = v.e_stall; o_flush = v.e_flush;
      o_bubble = v.e_bubble; o_busy = v.e_busy; o_sc = v.e_sc;
    end
    check("issue", 32'(issue), 32'(o_issue));
    check("stall_fe", 32'(stall_fe), 32'(o_stall));
    check("flush_fe", 32'(flush_fe), 32'(o_flush));
    check("bubble_ex", 32'(bubble_ex), 32'(o_bubble));
    check("busy_mask", 32'(busy_mask), 32'(o_busy));
    check("stall_cycles", 32'(stall_cycles), 32'(o_sc));
    // Advance the model using the spec-derived decisions, not the table values.
    if (v.rst) begin
      m_br = 0; m_sc = 0;
      for (int r = 0; r < NREG; r++) m_free[r] = 0;
    end else begin
      bit iss;
      iss = !m_br && !haz && v.valid;
      if (iss && v.wb[2]) m_free[v.d] = cyc + 1 + latency(v.mem);
      if (!m_br && haz && m_sc < SC_MAX) m_sc++;
      if (m_br) begin
        if (v.res) m_br = 0;
      end else if (iss && transfers(v.op)) begin
        m_br = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vec_t rv;
    for (int r = 0; r < NREG; r++) m_free[r] = 0;
    rst = 1; id_valid = 0; id_opcode = 0; id_src1 = 0; id_src2 = 0; id_dest = 0;
    id_wb = 0; id_mem = 0; ex_br_resolved = 0; ex_br_taken = 0;
    @(posedge clk);
    #1;
    cyc = 1;

    //            rst v  op     s1 s2 d  wb      mem    res tkn  is st fl bu busy   sc
    vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 1, 8'h00, 0));
`ifdef FWD_EN
    vecs.push_back(mk(0, 1, 4'h4, 2, 0, 1, 3'b100, 2'b01, 0, 0, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 4'h0, 1, 2, 3, 3'b100, 2'b00, 0, 0, 0, 1, 0, 1, 8'h02, 0));
    vecs.push_back(mk(0, 1, 4'h0, 1, 2, 3, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h4, 2, 0, 1, 3'b100, 2'b01, 0, 0, 1, 0, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h3, 0, 0, 1, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 8'h02, 1));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 1, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h8, 0, 6, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h3, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h3, 0, 0, 0, 3'b000, 2'b00, 1, 1, 0, 0, 1, 1, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h0, 3, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h9, 0, 0, 2, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h0, 3, 0, 0, 3'b000, 2'b00, 1, 0, 0, 1, 0, 1, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h0, 3, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'hB, 3, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 1));
    vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 1, 8'h00, 1));
    vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 0));
`else
    vecs.push_back(mk(0, 1, 4'h0, 2, 0, 1, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 1, 4'h2, 1, 4, 5, 3'b100, 2'b00, 0, 0, 0, 1, 0, 1, 8'h02, 0));
    vecs.push_back(mk(0, 1, 4'h2, 1, 4, 5, 3'b100, 2'b00, 0, 0, 0, 1, 0, 1, 8'h02, 1));
    vecs.push_back(mk(0, 1, 4'h2, 1, 4, 5, 3'b100, 2'b00, 0, 0, 0, 1, 0, 1, 8'h02, 2));
    vecs.push_back(mk(0, 1, 4'h2, 1, 4, 5, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 3));
    vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 1, 8'h20, 3));
    vecs.push_back(mk(0, 1, 4'h8, 0, 6, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 8'h20, 3));
    vecs.push_back(mk(0, 1, 4'h3, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 8'h20, 3));
    vecs.push_back(mk(0, 1, 4'h3, 0, 0, 0, 3'b000, 2'b00, 1, 1, 0, 0, 1, 1, 8'h00, 3));
    vecs.push_back(mk(0, 1, 4'h3, 0, 0, 7, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 3));
    vecs.push_back(mk(0, 1, 4'h9, 0, 0, 2, 3'b100, 2'b00, 0, 0, 1, 0, 0, 0, 8'h80, 3));
    vecs.push_back(mk(0, 1, 4'h0, 3, 0, 0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 1, 8'h84, 3));
    vecs.push_back(mk(0, 1, 4'h0, 3, 0, 0, 3'b000, 2'b00, 1, 0, 0, 1, 0, 1, 8'h84, 3));
    vecs.push_back(mk(0, 1, 4'h0, 3, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 8'h04, 3));
    vecs.push_back(mk(0, 1, 4'hB, 3, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 3));
    vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 1, 8'h00, 3));
    vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0, 8'h00, 0));
`endif
    foreach (vecs[i]) run_cycle(vecs[i], 1'b1);

    for (int n = 0; n < 3000; n++) begin
      rv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rv.rst   = ($urandom_range(0, 99) == 0);
      rv.valid = ($urandom_range(0, 3) != 0);
      rv.op    = 4'($urandom);
      rv.s1    = 3'($urandom);
      rv.s2    = 3'($urandom);
      rv.d     = 3'($urandom);
      rv.wb    = 3'($urandom);
      rv.mem   = 2'($urandom);
      rv.res   = ($urandom_range(0, 3) == 0);
      rv.tkn   = 1'($urandom);
      run_cycle(rv, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

- Pipeline sequencing controller for the 16-bit RISC core.
- Sits between the instruction decoder (ID stage) and the fetch/ID-EX pipeline registers.
- Tracks pending register writes in a per-register countdown scoreboard and holds dependent instructions in ID.
- Freezes fetch while a control-transfer instruction is unresolved and flushes the wrong-path fetch on a taken branch or jump.

## Interface
Parameters:
- NREG, 8: architectural registers; scoreboard entries.
- WB_DIST, 3: stall distance for any write when forwarding is compiled out.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_opcode  in  4  instruction[15:12].
- id_src1, id_src2, id_dest  in  3 each  decoder register fields.
- id_wb  in  3  decoder WB code; id_wb[2]=1 means a register write.
- id_mem  in  2  decoder Mem code; 01 is a load.
- ex_br_resolved  in  1  branch or jump resolved in EX this cycle.
- ex_br_taken  in  1  PC redirect taken; valid only with ex_br_resolved.
- issue  out  1  ID instruction advances into ID/EX this cycle.
- stall_fe  out  1  hold PC and IF/ID.
- flush_fe  out  1  invalidate IF/ID.
- bubble_ex  out  1  load a NOP into ID/EX.
- busy_mask  out  NREG  registered; bit r set while cnt[r]!=0.
- stall_cycles  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
Source usage by opcode:
- 0001, 0010, 0101, 1000: src1 and src2.
- 0000, 0100, 1011: src1 only.
- 1010: src2 only.
- 0011, 1001, other opcodes: no sources.

Control-transfer opcodes: 1000, 1001, 1010, 1011.

Hazard condition:
- hazard = id_valid and (uses src1 and cnt[id_src1]!=0, or uses src2 and cnt[id_src2]!=0).

Scoreboard:
- One 2-bit counter cnt[r] per register.
- Every cycle, each nonzero counter decrements by 1.
- On issue with id_wb[2]=1, cnt[id_dest] is loaded with the latency value (see Configuration).
- If the load and a decrement hit the same entry in one cycle, the load wins.
- Conditional ADD/NDU variants are scoreboarded as unconditional writes.
- Condition flags are always forwarded and never stall.

FSM:
- RUN:
  - hazard: stall_fe=1, bubble_ex=1, issue=0.
  - id_valid with no hazard: issue=1, stall_fe=0, bubble_ex=0; a control-transfer opcode moves to BR_WAIT.
  - id_valid=0: issue=0, stall_fe=0, bubble_ex=1.
  - ex_br_resolved is ignored.
- BR_WAIT:
  - issue=0, bubble_ex=1, stall_fe=1.
  - On ex_br_resolved with ex_br_taken=1: flush_fe=1, stall_fe=0, next state RUN.
  - On ex_br_resolved with ex_br_taken=0: stall_fe stays 1 so the fall-through instruction is kept, next state RUN.
  - No timeout; waits indefinitely.

stall_cycles:
- Increments on every RUN cycle with hazard=1.
- Saturates at all-ones.

flush_fe is 0 in every case not listed above.

## Timing
- While rst=1: issue=0, stall_fe=0, flush_fe=0, bubble_ex=1.
- On the first edge with rst=1: state←RUN, all cnt←0, busy_mask←0, stall_cycles←0.
- Reset in BR_WAIT or mid-stall aborts immediately; no flush is emitted.
- issue, stall_fe, flush_fe and bubble_ex are combinational from current state and inputs; no added latency.
- Scoreboard latency: counter value L loaded at issue cycle t means a dependent instruction in ID stalls for L cycles and issues at t+1+L.
- Earliest resolution: a branch issued at cycle t resolves at t+1; flush_fe is then asserted at t+1 and RUN resumes at t+2.

## Configuration
- FWD_EN defined: loads (id_mem=01) load cnt=1; all other writes load cnt=0 (full EX/MEM forwarding assumed).
- FWD_EN undefined: every write loads cnt=WB_DIST; no forwarding assumed.
- WB_DIST must fit in 2 bits (value 1 to 3).

## Test plan
- Reset with id_valid=0 → issue=0, bubble_ex=1, busy_mask=8'h00, stall_cycles=0; reset asserted in BR_WAIT → RUN next cycle, busy_mask=0.
- FWD_EN: LW r1 issues at t, then ADD r3,r1,r2 in ID at t+1 → stall_fe=1 and bubble_ex=1 at t+1 only; issue=1 at t+2; stall_cycles=1.
- No FWD_EN: ADD writes r1 at t, then NDU reads r1 → stall cycles t+1 to t+3, issue at t+4, stall_cycles=3.
- FWD_EN: LW r1, then LHI r1 (no sources) → issues at t+1, no stall; busy_mask[1] stays set one cycle, then clears.
- BEQ issues at t; ex_br_resolved=1 with taken=1 at t+2 → stall_fe=1 at t+1, flush_fe=1 and stall_fe=0 at t+2, issue possible at t+3.
- JAL issues; resolved not-taken → stall_fe=1 in the resolve cycle, flush_fe=0, held instruction issues the next cycle; busy_mask set for JAL's destination register.
